// File: rtl/vme_lbus_pkg.sv
// Shared types and constants for the VME local-bus master.
//   state_e     : bus-cycle FSM states
//   LAD_W       : multiplexed address/data bus width
//   *_TMO_DEF   : default timeout lengths in clock cycles
//   TMO_W       : width of the shared timeout down-counter
//   lowest_set  : index of the lowest set bit (0 when none set)
package vme_lbus_pkg;

  localparam int LAD_W         = 32;
  localparam int NLINT         = 8;
  localparam int VEC_W         = 3;
  localparam int HOLD_TMO_DEF  = 16;
  localparam int READY_TMO_DEF = 64;
  localparam int TMO_W         = 7;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    ADDR,
    WAIT,
    DONE,
    ERR_ST,
    REL
  } state_e;

  // Scan from the top down so the lowest set bit is the last to write idx.
  function automatic logic [VEC_W-1:0] lowest_set(input logic [NLINT-1:0] v);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = NLINT - 1; i >= 0; i--) begin
      if (v[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vme_lbus_if.sv
// Request/response port between the VME slave core and the local-bus master.
//   master modport : slave core side (issues req, receives ack/err/rdata)
//   slave modport  : local-bus master side (accepts req, returns ack/err/rdata)
//   req            : held high until ack or err
//   req_r_wn       : 1=read, 0=write
//   req_addr/be/wdata : access address, active-high byte enables, write data
//   rdata          : read data, valid with ack, held until the next read ack
//   ack/err        : one-cycle completion / timeout pulses
//   busy           : master is not idle
interface vme_lbus_if;
  import vme_lbus_pkg::*;

  logic             req;
  logic             req_r_wn;
  logic [LAD_W-1:0] req_addr;
  logic [3:0]       req_be;
  logic [LAD_W-1:0] req_wdata;
  logic [LAD_W-1:0] rdata;
  logic             ack;
  logic             err;
  logic             busy;

  modport master (
    output req, req_r_wn, req_addr, req_be, req_wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, req_r_wn, req_addr, req_be, req_wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/vme_lint_sync.sv
// Local interrupt front end: double-flop synchroniser on the active-low
// LINTIn lines, mask, and lowest-index priority encode.
//   i_clock     : system clock
//   i_resetn    : synchronous active-low reset
//   i_lintin    : asynchronous active-low interrupt lines
//   i_int_mask  : 1 = line enabled (applied after the synchroniser)
//   o_irq_req   : any enabled line active
//   o_int_vec   : lowest active enabled line, 0 when none
module vme_lint_sync
  import vme_lbus_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic [NLINT-1:0] i_lintin,
  input  logic [NLINT-1:0] i_int_mask,
  output logic             o_irq_req,
  output logic [VEC_W-1:0] o_int_vec
);

  logic [NLINT-1:0] r_sync1;
  logic [NLINT-1:0] r_sync2;
  logic             r_irq_req;
  logic [VEC_W-1:0] r_int_vec;
  logic [NLINT-1:0] w_active;

  // Mask sits after the synchroniser so a mask change shows up one cycle later.
  assign w_active = ~r_sync2 & i_int_mask;

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_irq_req <= 1'b0;
      r_int_vec <= '0;
    end else begin
      r_sync1   <= i_lintin;
      r_sync2   <= r_sync1;
      r_irq_req <= |w_active;
      r_int_vec <= lowest_set(w_active);
    end
  end

  assign o_irq_req = r_irq_req;
  assign o_int_vec = r_int_vec;

endmodule

// File: rtl/vme_lbus_master.sv
// Runs one single-cycle VME access on the multiplexed local bus:
// LHOLD/LHOLDA arbitration, one-cycle ADSn address phase, data phase ended
// by READYn, with hold and ready timeouts reported as err.
//   i_clock, i_resetn : clock, synchronous active-low reset
//   req_if            : request/response port (slave modport)
//   o_lhold/i_lholda  : local bus request / grant
//   io_lad_bus        : multiplexed address/data
//   o_adsn, o_lw_rn, o_lben, i_readyn : local bus strobes and target ready
//   i_lintin, i_int_mask, o_irq_req, o_int_vec : interrupt front end
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on acceptance
// HOLD   | LHOLD high, waiting for LHOLDA (hold timeout)
// ADDR   | ADSn low, address driven, one cycle
// WAIT   | data phase, waiting for READYn (ready timeout)
// DONE   | ack pulse, bus released
// ERR_ST | err pulse, bus released
// REL    | waiting for LHOLDA to drop
module vme_lbus_master
  import vme_lbus_pkg::*;
#(
  parameter int HOLD_TMO  = HOLD_TMO_DEF,
  parameter int READY_TMO = READY_TMO_DEF
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  vme_lbus_if.slave        req_if,
  output logic             o_lhold,
  input  logic             i_lholda,
  inout  wire  [LAD_W-1:0] io_lad_bus,
  output logic             o_adsn,
  output logic             o_lw_rn,
  output logic [3:0]       o_lben,
  input  logic             i_readyn,
  input  logic [NLINT-1:0] i_lintin,
  input  logic [NLINT-1:0] i_int_mask,
  output logic             o_irq_req,
  output logic [VEC_W-1:0] o_int_vec
);

  state_e           r_state;
  logic [TMO_W-1:0] r_timer;
  logic             r_rwn;
  logic [LAD_W-1:2] r_addr;
  logic [3:0]       r_be;
  logic [LAD_W-1:0] r_wdata;
  logic [LAD_W-1:0] r_rdata;
  logic             r_lhold;
  logic             r_adsn;
  logic             r_lw_rn;
  logic [3:0]       r_lben;
  logic             r_ack;
  logic             r_err;
  logic             r_busy;

  state_e           w_state_nxt;
  logic [TMO_W-1:0] w_timer_nxt;
  logic             w_ld_req;
  logic             w_cap_rd;
  logic             w_lad_oe;
  logic [LAD_W-1:0] w_lad_out;
  logic             w_unused_addr;

  assign w_unused_addr = ^req_if.req_addr[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_ld_req    = 1'b0;
    w_cap_rd    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_if.req) begin
          w_state_nxt = HOLD;
          w_timer_nxt = TMO_W'(HOLD_TMO - 1);
          w_ld_req    = 1'b1;
        end
      end
      HOLD: begin
        if (i_lholda)             w_state_nxt = ADDR;
        else if (r_timer == '0)   w_state_nxt = ERR_ST;
        else                      w_timer_nxt = r_timer - TMO_W'(1);
      end
      ADDR: begin
        w_state_nxt = WAIT;
        w_timer_nxt = TMO_W'(READY_TMO - 1);
      end
      WAIT: begin
        if (!i_readyn) begin
          w_state_nxt = DONE;
          w_cap_rd    = r_rwn;
        end else if (r_timer == '0) begin
          w_state_nxt = ERR_ST;
        end else begin
          w_timer_nxt = r_timer - TMO_W'(1);
        end
      end
      DONE, ERR_ST: w_state_nxt = REL;
      REL: begin
        if (!i_lholda) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus-side outputs are registered from the next state so each one is
  // aligned with the state it belongs to.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_rwn   <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_lhold <= 1'b0;
      r_adsn  <= 1'b1;
      r_lw_rn <= 1'b0;
      r_lben  <= 4'hF;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_ld_req) begin
        r_rwn   <= req_if.req_r_wn;
        r_addr  <= req_if.req_addr[LAD_W-1:2];
        r_be    <= req_if.req_be;
        r_wdata <= req_if.req_wdata;
      end
      if (w_cap_rd) r_rdata <= io_lad_bus;
      r_lhold <= (w_state_nxt == HOLD) || (w_state_nxt == ADDR) || (w_state_nxt == WAIT);
      r_adsn  <= (w_state_nxt != ADDR);
      if ((w_state_nxt == ADDR) || (w_state_nxt == WAIT)) begin
        r_lw_rn <= ~r_rwn;
        r_lben  <= ~r_be;
      end else begin
        r_lw_rn <= 1'b0;
        r_lben  <= 4'hF;
      end
      r_ack  <= (w_state_nxt == DONE);
      r_err  <= (w_state_nxt == ERR_ST);
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  // The bus driver decodes the current state directly so it releases in the
  // same cycle the FSM leaves ADDR/WAIT.
  assign w_lad_oe   = (r_state == ADDR) || ((r_state == WAIT) && !r_rwn);
  assign w_lad_out  = (r_state == ADDR) ? {r_addr, 2'b00} : r_wdata;
  assign io_lad_bus = w_lad_oe ? w_lad_out : {LAD_W{1'bz}};

  assign o_lhold     = r_lhold;
  assign o_adsn      = r_adsn;
  assign o_lw_rn     = r_lw_rn;
  assign o_lben      = r_lben;
  assign req_if.rdata = r_rdata;
  assign req_if.ack   = r_ack;
  assign req_if.err   = r_err;
  assign req_if.busy  = r_busy;

  vme_lint_sync u_lint_sync (
    .i_clock    (i_clock),
    .i_resetn   (i_resetn),
    .i_lintin   (i_lintin),
    .i_int_mask (i_int_mask),
    .o_irq_req  (o_irq_req),
    .o_int_vec  (o_int_vec)
  );

endmodule

// File: tb/tb_vme_lbus_master.sv
// Directed bench for vme_lbus_master: transaction table, interrupt table and
// hand-written sequences for timeouts, reset abort and back-to-back requests.
module tb_vme_lbus_master;

  logic        clk;
  logic        resetn;
  logic        lholda;
  logic        readyn;
  logic [7:0]  lintin;
  logic [7:0]  int_mask;
  logic        lhold;
  logic        adsn;
  logic        lw_rn;
  logic [3:0]  lben;
  logic        irq_req;
  logic [2:0]  int_vec;
  logic        tb_oe;
  logic [31:0] tb_val;
  wire  [31:0] lad_bus;

  int n_checks = 0;
  int n_fail   = 0;

  vme_lbus_if u_if ();

  assign lad_bus = tb_oe ? tb_val : 32'bz;

  vme_lbus_master dut (
    .i_clock    (clk),
    .i_resetn   (resetn),
    .req_if     (u_if),
    .o_lhold    (lhold),
    .i_lholda   (lholda),
    .io_lad_bus (lad_bus),
    .o_adsn     (adsn),
    .o_lw_rn    (lw_rn),
    .o_lben     (lben),
    .i_readyn   (readyn),
    .i_lintin   (lintin),
    .i_int_mask (int_mask),
    .o_irq_req  (irq_req),
    .o_int_vec  (int_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rwn;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] tdata;
    int          dly;
    logic [31:0] exp_lad;
    logic [3:0]  exp_lben;
    logic [31:0] exp_rdata;
  } xact_t;

  typedef struct {
    logic [7:0] lint;
    logic [7:0] mask;
    logic       exp_irq;
    logic [2:0] exp_vec;
  } irq_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts from IDLE with LHOLDA high; READYn low dly cycles into WAIT
  // (with dly==0 READYn is low from the request on, so HOLD/ADDR must ignore it).
  task automatic run_xact(input xact_t x, input int id);
    u_if.req       = 1'b1;
    u_if.req_r_wn  = x.rwn;
    u_if.req_addr  = x.addr;
    u_if.req_be    = x.be;
    u_if.req_wdata = x.wdata;
    lholda         = 1'b1;
    readyn         = (x.dly == 0) ? 1'b0 : 1'b1;
    tick();
    check1($sformatf("x%0d_hold_lhold", id), lhold, 1'b1);
    check1($sformatf("x%0d_hold_busy", id), u_if.busy, 1'b1);
    check1($sformatf("x%0d_hold_adsn", id), adsn, 1'b1);
    tick();
    check1($sformatf("x%0d_addr_adsn", id), adsn, 1'b0);
    check32($sformatf("x%0d_addr_lad", id), lad_bus, x.exp_lad);
    check1($sformatf("x%0d_addr_lw_rn", id), lw_rn, ~x.rwn);
    check32($sformatf("x%0d_addr_lben", id), 32'(lben), 32'(x.exp_lben));
    for (int k = 0; k <= x.dly; k++) begin
      tick();
      if (k == x.dly) begin
        readyn = 1'b0;
        if (x.rwn) begin
          tb_oe  = 1'b1;
          tb_val = x.tdata;
        end
      end
      check1($sformatf("x%0d_wait%0d_adsn", id, k), adsn, 1'b1);
      check1($sformatf("x%0d_wait%0d_ack", id, k), u_if.ack, 1'b0);
      check1($sformatf("x%0d_wait%0d_err", id, k), u_if.err, 1'b0);
      check1($sformatf("x%0d_wait%0d_lw_rn", id, k), lw_rn, ~x.rwn);
      check32($sformatf("x%0d_wait%0d_lben", id, k), 32'(lben), 32'(x.exp_lben));
      if (!x.rwn) check32($sformatf("x%0d_wait%0d_wdata", id, k), lad_bus, x.wdata);
    end
    tick();
    tb_oe     = 1'b0;
    readyn    = 1'b1;
    u_if.req  = 1'b0;
    check1($sformatf("x%0d_done_ack", id), u_if.ack, 1'b1);
    check1($sformatf("x%0d_done_err", id), u_if.err, 1'b0);
    check1($sformatf("x%0d_done_lhold", id), lhold, 1'b0);
    check1($sformatf("x%0d_done_oe", id), dut.w_lad_oe, 1'b0);
    check32($sformatf("x%0d_done_rdata", id), u_if.rdata, x.exp_rdata);
    tick();
    check1($sformatf("x%0d_rel_ack", id), u_if.ack, 1'b0);
    check1($sformatf("x%0d_rel_busy", id), u_if.busy, 1'b1);
    check32($sformatf("x%0d_rel_lben", id), 32'(lben), 32'hF);
    lholda = 1'b0;
    tick();
    check1($sformatf("x%0d_idle_busy", id), u_if.busy, 1'b0);
    lholda = 1'b1;
  endtask

  xact_t    xt [4];
  irq_vec_t it [6];
  xact_t    post_rst;
  int       adsn_lows;

  initial begin
    xt[0] = '{1'b1, 32'h5500_0008, 4'hF, 32'h0,         32'hCAFE_F00D, 0, 32'h5500_0008, 4'h0, 32'hCAFE_F00D};
    xt[1] = '{1'b0, 32'h5500_0004, 4'h3, 32'h0000_0055, 32'h0,         5, 32'h5500_0004, 4'hC, 32'hCAFE_F00D};
    xt[2] = '{1'b1, 32'h1234_567B, 4'hC, 32'h0,         32'h0BAD_BEEF, 2, 32'h1234_5678, 4'h3, 32'h0BAD_BEEF};
    xt[3] = '{1'b0, 32'hFFFF_FFFF, 4'h8, 32'hDEAD_BEEF, 32'h0,         1, 32'hFFFF_FFFC, 4'h7, 32'h0BAD_BEEF};
    post_rst = '{1'b1, 32'h0000_0100, 4'hF, 32'h0, 32'h1357_9BDF, 0, 32'h0000_0100, 4'h0, 32'h1357_9BDF};

    it[0] = '{8'hFF, 8'hFF, 1'b0, 3'd0};
    it[1] = '{8'h00, 8'hFF, 1'b1, 3'd0};
    it[2] = '{8'h7F, 8'hFF, 1'b1, 3'd7};
    it[3] = '{8'h7F, 8'h7F, 1'b0, 3'd0};
    it[4] = '{8'hAA, 8'hFE, 1'b1, 3'd2};
    it[5] = '{8'h00, 8'h30, 1'b1, 3'd4};

    resetn = 1'b0; lholda = 1'b0; readyn = 1'b1; lintin = 8'hFF; int_mask = 8'h00;
    tb_oe = 1'b0; tb_val = '0;
    u_if.req = 1'b0; u_if.req_r_wn = 1'b0; u_if.req_addr = '0; u_if.req_be = '0; u_if.req_wdata = '0;
    tick(); tick(); tick();
    check1("rst_lhold", lhold, 1'b0);
    check1("rst_adsn", adsn, 1'b1);
    check1("rst_lw_rn", lw_rn, 1'b0);
    check32("rst_lben", 32'(lben), 32'hF);
    check1("rst_ack", u_if.ack, 1'b0);
    check1("rst_err", u_if.err, 1'b0);
    check1("rst_busy", u_if.busy, 1'b0);
    check32("rst_rdata", u_if.rdata, 32'h0);
    check1("rst_irq", irq_req, 1'b0);
    check32("rst_vec", 32'(int_vec), 32'h0);
    check1("rst_oe", dut.w_lad_oe, 1'b0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_xact(xt[i], i);

    // Ready timeout: READYn never low, err 64 cycles after the first WAIT cycle.
    u_if.req = 1'b1; u_if.req_r_wn = 1'b1; u_if.req_addr = 32'h2000_0000; u_if.req_be = 4'hF;
    lholda = 1'b1; readyn = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      tick();
      if (c < 67) check1($sformatf("rtmo_c%0d_err", c), u_if.err, 1'b0);
    end
    check1("rtmo_err", u_if.err, 1'b1);
    check1("rtmo_ack", u_if.ack, 1'b0);
    check1("rtmo_lhold", lhold, 1'b0);
    check32("rtmo_rdata", u_if.rdata, 32'h0BAD_BEEF);
    u_if.req = 1'b0;
    tick();
    check1("rtmo_err_pulse", u_if.err, 1'b0);
    check1("rtmo_rel_busy", u_if.busy, 1'b1);
    lholda = 1'b0;
    tick();
    check1("rtmo_idle_busy", u_if.busy, 1'b0);

    // Hold timeout: LHOLDA never granted, err 16 cycles after LHOLD rises.
    u_if.req = 1'b1; u_if.req_r_wn = 1'b0; u_if.req_addr = 32'h2000_0010; u_if.req_wdata = 32'h1;
    adsn_lows = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (!adsn) adsn_lows++;
      if (c < 17) begin
        check1($sformatf("htmo_c%0d_err", c), u_if.err, 1'b0);
        check1($sformatf("htmo_c%0d_lhold", c), lhold, 1'b1);
      end
    end
    check1("htmo_err", u_if.err, 1'b1);
    check1("htmo_lhold", lhold, 1'b0);
    check32("htmo_adsn_lows", 32'(adsn_lows), 32'h0);
    u_if.req = 1'b0;
    tick();
    check1("htmo_err_pulse", u_if.err, 1'b0);
    tick();
    check1("htmo_idle_busy", u_if.busy, 1'b0);

    // REQ held through ack: no reissue until IDLE; second request dropped early.
    u_if.req = 1'b1; u_if.req_r_wn = 1'b1; u_if.req_addr = 32'h3000_0000; u_if.req_be = 4'hF;
    lholda = 1'b1; readyn = 1'b0;
    tick(); tick(); tick();
    tb_oe = 1'b1; tb_val = 32'h1111_2222;
    tick();
    tb_oe = 1'b0;
    check1("b2b_ack1", u_if.ack, 1'b1);
    check32("b2b_rdata1", u_if.rdata, 32'h1111_2222);
    for (int c = 5; c <= 7; c++) begin
      tick();
      check1($sformatf("b2b_rel%0d_ack", c), u_if.ack, 1'b0);
      check1($sformatf("b2b_rel%0d_lhold", c), lhold, 1'b0);
      check1($sformatf("b2b_rel%0d_busy", c), u_if.busy, 1'b1);
    end
    lholda = 1'b0;
    tick();
    check1("b2b_idle_busy", u_if.busy, 1'b0);
    check1("b2b_idle_lhold", lhold, 1'b0);
    lholda = 1'b1;
    tick();
    check1("b2b_hold2_lhold", lhold, 1'b1);
    u_if.req = 1'b0;
    tick();
    check1("b2b_addr2_adsn", adsn, 1'b0);
    tick();
    tb_oe = 1'b1; tb_val = 32'h3333_4444;
    tick();
    tb_oe = 1'b0;
    check1("b2b_ack2", u_if.ack, 1'b1);
    check32("b2b_rdata2", u_if.rdata, 32'h3333_4444);
    tick();
    lholda = 1'b0;
    tick();
    check1("b2b_idle2_busy", u_if.busy, 1'b0);
    lholda = 1'b1; readyn = 1'b1;

    // Reset during WAIT of a write aborts the cycle.
    u_if.req = 1'b1; u_if.req_r_wn = 1'b0; u_if.req_addr = 32'h4000_0000;
    u_if.req_wdata = 32'hA5A5_A5A5; u_if.req_be = 4'hF;
    tick(); tick(); tick();
    check32("rstw_wait_lad", lad_bus, 32'hA5A5_A5A5);
    check1("rstw_wait_oe", dut.w_lad_oe, 1'b1);
    tick();
    resetn = 1'b0;
    tick();
    check1("rstw_lhold", lhold, 1'b0);
    check1("rstw_adsn", adsn, 1'b1);
    check1("rstw_oe", dut.w_lad_oe, 1'b0);
    check1("rstw_busy", u_if.busy, 1'b0);
    check32("rstw_lben", 32'(lben), 32'hF);
    check32("rstw_rdata", u_if.rdata, 32'h0);
    resetn = 1'b1;
    u_if.req = 1'b0;
    tick();
    run_xact(post_rst, 9);

    // Interrupts: LINTIn=F3, mask F8 -> line 3 after three cycles.
    lintin = 8'hF3; int_mask = 8'hF8;
    tick(); tick();
    check1("irq_c2_req", irq_req, 1'b0);
    tick();
    check1("irq_c3_req", irq_req, 1'b1);
    check32("irq_c3_vec", 32'(int_vec), 32'h3);
    int_mask = 8'h00;
    tick();
    check1("irq_mask0_req", irq_req, 1'b0);
    check32("irq_mask0_vec", 32'(int_vec), 32'h0);

    for (int i = 0; i < 6; i++) begin
      lintin   = it[i].lint;
      int_mask = it[i].mask;
      tick(); tick(); tick();
      check1($sformatf("irqtab%0d_req", i), irq_req, it[i].exp_irq);
      check32($sformatf("irqtab%0d_vec", i), 32'(int_vec), 32'(it[i].exp_vec));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
